// File: rtl/pagerank_update_writer.sv
// pagerank_update_writer
// Applies the PageRank update for one node at a time:
//   new_rank = BASE + DAMP * sum   (Q16.16, saturating)
// The old rank is read from a rank BRAM with a one-cycle registered read.
// The new rank is written back. The largest |new - old| seen in an
// iteration is tracked, and iter_done/converged are reported once all
// NUM_NODES ranks have been written.
module pagerank_update_writer #(
  parameter int          NUM_NODES = 10,
  parameter logic [31:0] DAMP      = 32'h0000_D99A,
  parameter logic [31:0] BASE      = 32'h0000_03D7,
  parameter logic [31:0] EPS       = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] sum_pagerank,
  input  logic [3:0]  node_idx,
  output logic [3:0]  bram_addr,
  output logic        bram_we,
  output logic [31:0] bram_wdata,
  input  logic [31:0] bram_rdata,
  output logic        iter_done,
  output logic        converged,
  output logic        sat_flag,
  output logic        err_idx
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_CAP  = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  // Node count needs 5 bits so that a full 16-node iteration is representable.
  localparam logic [4:0] NODES_C = 5'(NUM_NODES);

  // Unsigned absolute difference of two ranks.
  function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = b - a;
    end
    return r;
  endfunction

  // Saturating result: any product bits above Q16.16 range or a carry out of
  // the final addition force the all-ones rank.
  function automatic logic [32:0] sat_add(input logic [63:0] prod, input logic [31:0] base);
    logic [32:0] s;
    logic        ovf;
    s   = {1'b0, base} + {1'b0, prod[47:16]};
    ovf = (prod[63:48] != 16'h0000) || s[32];
    if (ovf) begin
      return {1'b1, 32'hFFFF_FFFF};
    end else begin
      return {1'b0, s[31:0]};
    end
  endfunction

  logic [2:0]  state_q, state_d;
  logic        in_ready_q, in_ready_d;
  logic [31:0] sum_q, sum_d;
  logic        idx_ok_q, idx_ok_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] old_q, old_d;
  logic [31:0] new_q, new_d;
  logic [3:0]  addr_q, addr_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] max_delta_q, max_delta_d;
  logic        iter_done_q, iter_done_d;
  logic        converged_q, converged_d;
  logic        sat_q, sat_d;
  logic        err_q, err_d;

  logic        idx_ok_s;
  logic [32:0] sat_res_s;
  logic [31:0] delta_s;
  logic        prod_lo_unused_s;

  assign idx_ok_s  = ({1'b0, node_idx} < NODES_C);
  assign sat_res_s = sat_add(prod_q, BASE);
  assign delta_s   = abs_diff(new_q, old_q);
  // The fractional bits below Q16.16 precision are dropped by design.
  assign prod_lo_unused_s = ^prod_q[15:0];

  // Next-state and datapath computation for the update sequence.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    idx_ok_d    = idx_ok_q;
    prod_d      = prod_q;
    old_d       = old_q;
    new_d       = new_q;
    addr_d      = addr_q;
    we_d        = 1'b0;
    wdata_d     = wdata_q;
    count_d     = count_q;
    max_delta_d = max_delta_q;
    iter_done_d = 1'b0;
    converged_d = converged_q;
    sat_d       = sat_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sum_d    = sum_pagerank;
          idx_ok_d = idx_ok_s;
          addr_d   = node_idx;
          err_d    = err_q | ~idx_ok_s;
          state_d  = S_RD;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RD: begin
        prod_d  = 64'(DAMP) * 64'(sum_q);
        state_d = S_CAP;
      end
      S_CAP: begin
        old_d = bram_rdata;
        new_d = sat_res_s[31:0];
        if (idx_ok_q && sat_res_s[32]) begin
          sat_d = 1'b1;
        end else begin
          sat_d = sat_q;
        end
        state_d = S_WR;
      end
      S_WR: begin
        if (idx_ok_q) begin
          we_d    = 1'b1;
          wdata_d = new_q;
          count_d = count_q + 5'd1;
          if (delta_s > max_delta_q) begin
            max_delta_d = delta_s;
          end else begin
            max_delta_d = max_delta_q;
          end
        end else begin
          we_d = 1'b0;
        end
        state_d = S_FIN;
      end
      S_FIN: begin
        if (idx_ok_q && (count_q == NODES_C)) begin
          iter_done_d = 1'b1;
          converged_d = (max_delta_q <= EPS);
          count_d     = 5'd0;
          max_delta_d = 32'h0000_0000;
        end else begin
          iter_done_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      sum_q       <= 32'h0000_0000;
      idx_ok_q    <= 1'b0;
      prod_q      <= 64'h0000_0000_0000_0000;
      old_q       <= 32'h0000_0000;
      new_q       <= 32'h0000_0000;
      addr_q      <= 4'h0;
      we_q        <= 1'b0;
      wdata_q     <= 32'h0000_0000;
      count_q     <= 5'd0;
      max_delta_q <= 32'h0000_0000;
      iter_done_q <= 1'b0;
      converged_q <= 1'b0;
      sat_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      sum_q       <= sum_d;
      idx_ok_q    <= idx_ok_d;
      prod_q      <= prod_d;
      old_q       <= old_d;
      new_q       <= new_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      max_delta_q <= max_delta_d;
      iter_done_q <= iter_done_d;
      converged_q <= converged_d;
      sat_q       <= sat_d;
      err_q       <= err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign bram_addr  = addr_q;
  assign bram_we    = we_q;
  assign bram_wdata = wdata_q;
  assign iter_done  = iter_done_q;
  assign converged  = converged_q;
  assign sat_flag   = sat_q;
  assign err_idx    = err_q;

endmodule

// File: tb/tb_pagerank_update_writer.sv
// Scoreboard bench for pagerank_update_writer. The main instance uses the
// default parameters; a second instance with DAMP = 1.0 makes saturation
// reachable (with d = 0.85 the Q16.16 result can never overflow).
module tb_pagerank_update_writer;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [31:0] sum_pagerank;
  logic [3:0]  node_idx;

  logic        in_ready, bram_we, iter_done, converged, sat_flag, err_idx;
  logic [3:0]  bram_addr;
  logic [31:0] bram_wdata, bram_rdata;

  logic        in_ready2, bram_we2, iter_done2, converged2, sat_flag2, err_idx2;
  logic [3:0]  bram_addr2;
  logic [31:0] bram_wdata2;
  logic [31:0] zero_rdata;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t q1[$];
  wr_t q2[$];
  bit  qc[$];

  logic [31:0] mem [16];
  logic        bd_we;
  logic [3:0]  bd_addr;
  logic [31:0] bd_data;
  logic        prev_we, prev_we2, prev_iter;

  assign zero_rdata = 32'h0000_0000;

  pagerank_update_writer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sum_pagerank(sum_pagerank), .node_idx(node_idx),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .iter_done(iter_done), .converged(converged),
    .sat_flag(sat_flag), .err_idx(err_idx)
  );

  pagerank_update_writer #(.DAMP(32'h0001_0000)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .sum_pagerank(sum_pagerank), .node_idx(node_idx),
    .bram_addr(bram_addr2), .bram_we(bram_we2), .bram_wdata(bram_wdata2),
    .bram_rdata(zero_rdata), .iter_done(iter_done2), .converged(converged2),
    .sat_flag(sat_flag2), .err_idx(err_idx2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Rank BRAM model: registered read, write port, plus a bench backdoor.
  always @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end else if (bram_we) begin
      mem[bram_addr] <= bram_wdata;
    end
    bram_rdata <= mem[bram_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  // Monitor: pops expectations whenever the DUTs present a write or iter_done.
  always @(negedge clk) begin
    if (reset) begin
      if (bram_we) begin
        if (q1.size() == 0) begin
          unexpected("unexpected_write");
        end else begin
          wr_t e;
          e = q1.pop_front();
          chk("wr_addr", bram_addr, e.addr);
          chk("wr_data", bram_wdata, e.data);
          chk("wr_cycle", cyc, e.cyc);
        end
      end
      if (bram_we2) begin
        if (q2.size() == 0) begin
          unexpected("unexpected_write_d2");
        end else begin
          wr_t e;
          e = q2.pop_front();
          chk("wr_data_d2", bram_wdata2, e.data);
        end
      end
      if (prev_we && bram_we) unexpected("we_longer_than_one_cycle");
      if (iter_done) begin
        if (qc.size() == 0) begin
          unexpected("unexpected_iter_done");
        end else begin
          chk("converged", converged, qc.pop_front());
        end
      end
      if (prev_iter && iter_done) unexpected("iter_done_longer_than_one_cycle");
      prev_we   <= bram_we;
      prev_we2  <= bram_we2;
      prev_iter <= iter_done;
    end else begin
      prev_we   <= 1'b0;
      prev_we2  <= 1'b0;
      prev_iter <= 1'b0;
    end
  end

  task automatic set_mem(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_addr = a;
    bd_data = d;
    bd_we   = 1'b1;
    @(negedge clk);
    bd_we   = 1'b0;
  endtask

  task automatic issue(input logic [3:0] idx, input logic [31:0] sum, input bit wr,
                       input logic [31:0] e1, input logic [31:0] e2,
                       input bit last, input bit conv);
    int  lat;
    int  t;
    wr_t w;
    @(negedge clk);
    lat = 0;
    while (!in_ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!in_ready) begin
      chk("ready_timeout", in_ready, 1);
      return;
    end
    in_valid     = 1'b1;
    sum_pagerank = sum;
    node_idx     = idx;
    @(posedge clk);
    #1;
    t        = cyc;
    in_valid = 1'b0;
    if (wr) begin
      w.addr = idx;
      w.cyc  = t + 3;
      w.data = e1;
      q1.push_back(w);
      w.data = e2;
      q2.push_back(w);
    end
    if (last) qc.push_back(conv);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!in_ready && lat < 12);
    chk("accept_to_ready", lat, 4);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_bram_we"}, bram_we, 0);
    chk({tag, "_bram_addr"}, bram_addr, 0);
    chk({tag, "_bram_wdata"}, bram_wdata, 0);
    chk({tag, "_iter_done"}, iter_done, 0);
    chk({tag, "_converged"}, converged, 0);
    chk({tag, "_sat_flag"}, sat_flag, 0);
    chk({tag, "_err_idx"}, err_idx, 0);
  endtask

  // A ten-update sweep over nodes 0..9 with sum 1.0; last one closes the iteration.
  task automatic sweep(input bit conv);
    for (int i = 0; i < 10; i++) begin
      issue(4'(i), 32'h0001_0000, 1'b1, 32'h0000_DD71, 32'h0001_03D7, (i == 9), conv);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset        = 1'b0;
    in_valid     = 1'b0;
    sum_pagerank = 32'h0000_0000;
    node_idx     = 4'h0;
    bd_we        = 1'b0;
    bd_addr      = 4'h0;
    bd_data      = 32'h0000_0000;
    for (int i = 0; i < 16; i++) begin
      set_mem(4'(i), (i == 3) ? 32'h0000_0000 : 32'h0000_DD71);
    end
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;

    // Iteration 1: single update onto an empty rank, then an illegal index,
    // then the remaining nine nodes. Node 3 moved by 0xDD71 -> not converged.
    issue(4'd3, 32'h0001_0000, 1'b1, 32'h0000_DD71, 32'h0001_03D7, 1'b0, 1'b0);
    chk("err_idx_before_bad", err_idx, 0);
    issue(4'd12, 32'h0001_0000, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("err_idx_after_bad", err_idx, 1);
    for (int i = 0; i < 10; i++) begin
      if (i != 3) begin
        issue(4'(i), 32'h0001_0000, 1'b1, 32'h0000_DD71, 32'h0001_03D7, (i == 9), 1'b0);
      end
    end

    // Iteration 2: all ranks already at 0xDD71 -> converged.
    sweep(1'b1);
    chk("converged_level_it2", converged, 1);

    // Iteration 3: node 0 rank cleared -> not converged; flag holds until then.
    set_mem(4'd0, 32'h0000_0000);
    issue(4'd0, 32'h0001_0000, 1'b1, 32'h0000_DD71, 32'h0001_03D7, 1'b0, 1'b0);
    chk("converged_held", converged, 1);
    for (int i = 1; i < 10; i++) begin
      issue(4'(i), 32'h0001_0000, 1'b1, 32'h0000_DD71, 32'h0001_03D7, (i == 9), 1'b0);
    end
    chk("converged_level_it3", converged, 0);

    // Iteration 4: the same node ten times counts as a full iteration.
    for (int i = 0; i < 10; i++) begin
      issue(4'd5, 32'h0001_0000, 1'b1, 32'h0000_DD71, 32'h0001_03D7, (i == 9), 1'b1);
    end

    // Large sums: d=0.85 stays in range, DAMP=1.0 saturates.
    chk("sat_d2_before", sat_flag2, 0);
    issue(4'd2, 32'hFFFF_FFFF, 1'b1, 32'hD99A_03D6, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("sat_d2_after", sat_flag2, 1);
    chk("sat_d1_after", sat_flag, 0);
    issue(4'd4, 32'h0000_8000, 1'b1, 32'h0000_70A4, 32'h0000_83D7, 1'b0, 1'b0);
    chk("sat_d2_sticky", sat_flag2, 1);
    chk("err_idx_sticky", err_idx, 1);

    // Reset two edges after acceptance: no write, everything back to reset values.
    @(negedge clk);
    in_valid     = 1'b1;
    sum_pagerank = 32'h0001_0000;
    node_idx     = 4'd1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset_vals("midop_reset");
    chk("midop_reset_sat_d2", sat_flag2, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Count restarts at 0; node 2 still holds 0xD99A03D6 -> not converged.
    sweep(1'b0);

    repeat (8) @(negedge clk);
    chk("writes_drained", q1.size(), 0);
    chk("writes_drained_d2", q2.size(), 0);
    chk("iter_done_drained", qc.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
